flyback_feedback: RTL and testbench
===================================

FLYBACK_FEEDBACK -- requirements
Module: flyback_feedback

Interface
REQ-001 SHALL have parameter WINDOW, default 21, meaning comparator samples per measurement window (legal 2..31).
REQ-002 SHALL have parameter HI_THR, default 14, meaning high-sample count at or above which the duty code steps down.
REQ-003 SHALL have parameter LO_THR, default 6, meaning high-sample count at or below which the duty code steps up (LO_THR < HI_THR < WINDOW).
REQ-004 SHALL have parameter SETTLE, default 4, meaning cycles spent in SETTLE before the first window.
REQ-005 SHALL have parameter BLANK, default 2, meaning cycles ignored after each update.
REQ-006 clk  input  1  single clock; all flops on the rising edge.
REQ-007 rst_async_n  input  1  reset, asynchronous, active-low; internally synchronized (assert async, release through 2 flops).
REQ-008 cmp_async_i  input  1  analog comparator (1 = Vout above reference), asynchronous, 2-flop synchronized to cmp_s.
REQ-009 en_i  input  1  synchronous regulation enable.
REQ-010 dutycyc_o  output  2  duty-cycle code for the PWM controller.
REQ-011 upd_o  output  1  one-cycle strobe, high in the cycle dutycyc_o takes a decided value.
REQ-012 fault_o  output  1  comparator high for an entire window.

Function
REQ-013 cmp_s SHALL lag cmp_async_i by exactly 2 clk edges.
REQ-014 FSM states SHALL be SETTLE, MEASURE, DECIDE, BLANK.
REQ-015 SETTLE: count SETTLE cycles, then MEASURE; window and ones counters cleared on entry.
REQ-016 MEASURE: lasts exactly WINDOW cycles; 5-bit ones counter increments each cycle cmp_s=1; after the last cycle go DECIDE.
REQ-017 DECIDE (1 cycle): ones = WINDOW -> duty 00, fault_o=1; else ones >= HI_THR -> duty-1 saturating at 00; ones <= LO_THR -> duty+1 saturating at 11; otherwise hold; fault_o=0 whenever ones < WINDOW.
REQ-018 dutycyc_o and fault_o SHALL update on the edge leaving DECIDE; upd_o high for exactly that following cycle, even if the value is unchanged.
REQ-019 BLANK: BLANK cycles, cmp_s ignored, then MEASURE; steady-state update period = WINDOW+1+BLANK (24 by default).
REQ-020 en_i low at any edge: next state SETTLE, counters cleared, no upd_o, dutycyc_o and fault_o held; en_i low in DECIDE suppresses that decision.
REQ-021 en_i returning high: full SETTLE precedes next window.
REQ-022 Counters SHALL never wrap: ones saturates at WINDOW; window counter resets each window.

Reset
REQ-023 During reset: dutycyc_o=01, upd_o=0, fault_o=0, state SETTLE, all counters 0, sync flops 0.
REQ-024 Reset asserted mid-window SHALL abort the window with no upd_o; first upd_o after release comes on edge 2+SETTLE+WINDOW+1 (28 by default) with en_i high.

Configuration
REQ-025 Macro FLYBACK_FEEDBACK_SOFTSTART_EN defined: reset dutycyc_o=00; 2-bit ceiling reg resets to 00, increments (saturating at 11) in every DECIDE; the new duty is clamped to the incremented ceiling; en_i low does not reset the ceiling.
REQ-026 Macro undefined: no ceiling logic; reset dutycyc_o=01; behaviour per REQ-017.

Verification
REQ-027 Release reset with cmp_async_i=0, en_i=1 -> upd_o first high on edge 28, dutycyc_o 01->10, then 11 24 cycles later, then held 11 with upd_o every 24 cycles.
REQ-028 cmp_s high 15 of 21 window samples from duty 10 -> dutycyc_o=01; 10 of 21 -> dutycyc_o unchanged, upd_o still pulses.
REQ-029 cmp_async_i held 1 for a whole window from duty 11 -> dutycyc_o=00, fault_o=1; next window with 5 highs -> fault_o=0, dutycyc_o=01.
REQ-030 en_i low for 3 cycles mid-MEASURE -> no upd_o, outputs frozen; next upd_o exactly SETTLE+WINDOW+1=26 edges after en_i returns high.
REQ-031 rst_async_n low mid-window -> outputs at reset values immediately (no clock needed); recovery per REQ-024.
REQ-032 With FLYBACK_FEEDBACK_SOFTSTART_EN, cmp_async_i=0 -> dutycyc_o 00->01->10->11 over three updates, never skipping a code.

Source files
------------

// File: rtl/flyback_feedback.sv
// ----------------------------------------------------------------------------
// flyback_feedback
//
// Bang-bang regulation loop for a flyback converter. A comparator result
// (Vout above reference) is counted over a fixed measurement window. The
// count then steps a 2-bit duty-cycle code that goes to the PWM controller.
// After each update, a short blanking gap lets the converter respond before
// the next window starts.
//
// Sequence: SETTLE -> MEASURE (WINDOW samples) -> DECIDE (1 cycle) -> BLANK
//           -> MEASURE ...
// Dropping en_i returns the loop to SETTLE and keeps the outputs frozen.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_async_n  in   async active-low reset; asserts immediately and
//                     releases through a 2-flop synchronizer
//   cmp_async_i  in   asynchronous comparator, 2-flop synchronized
//   en_i         in   synchronous regulation enable
//   dutycyc_o    out  [1:0] duty-cycle code
//   upd_o        out  one-cycle strobe when dutycyc_o takes a decided value
//   fault_o      out  comparator was high for an entire window
//
// Configuration
//   FLYBACK_FEEDBACK_SOFTSTART_EN  when defined, the duty code starts at 00.
//                                  It is limited by a ceiling that rises by
//                                  one code per decision, so start-up walks
//                                  00->01->10->11.
// ----------------------------------------------------------------------------
module flyback_feedback #(
  parameter int WINDOW = 21,
  parameter int HI_THR = 14,
  parameter int LO_THR = 6,
  parameter int SETTLE = 4,
  parameter int BLANK  = 2
) (
  input  logic       clk,
  input  logic       rst_async_n,
  input  logic       cmp_async_i,
  input  logic       en_i,
  output logic [1:0] dutycyc_o,
  output logic       upd_o,
  output logic       fault_o
);

  localparam int CNT_W   = 5;
  localparam int TMR_MAX = (SETTLE > BLANK) ? SETTLE : BLANK;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
  localparam logic [1:0] DUTY_RST = 2'b00;
`else
  localparam logic [1:0] DUTY_RST = 2'b01;
`endif

  typedef enum logic [1:0] {
    S_SETTLE  = 2'd0,
    S_MEASURE = 2'd1,
    S_DECIDE  = 2'd2,
    S_BLANK   = 2'd3
  } state_t;

  // A full window forces the minimum code. Otherwise the code moves one
  // step toward regulation, saturating at 00 and 11.
  function automatic logic [1:0] step_duty(input logic [1:0]       duty,
                                           input logic [CNT_W-1:0] ones);
    logic [1:0] res;
    res = duty;
    if (ones == CNT_W'(WINDOW)) begin
      res = 2'b00;
    end else if (ones >= CNT_W'(HI_THR)) begin
      res = (duty == 2'b00) ? 2'b00 : duty - 2'd1;
    end else if (ones <= CNT_W'(LO_THR)) begin
      res = (duty == 2'b11) ? 2'b11 : duty + 2'd1;
    end
    return res;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? 2'b11 : v + 2'd1;
  endfunction

  // ---- reset synchronizer: async assert, 2-flop release ----
  logic rst_meta_q, rst_sync_q;
  logic rst_n;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  // ---- comparator synchronizer (cmp_s_q lags the pin by 2 edges) ----
  logic cmp_meta_q, cmp_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_async_i;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // ---- control FSM and counters ----
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [1:0]       duty_q, duty_d;
  logic             fault_q, fault_d;
  logic             upd_q, upd_d;
`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
  logic [1:0]       ceil_q, ceil_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SETTLE;
      tmr_q   <= '0;
      win_q   <= '0;
      ones_q  <= '0;
      duty_q  <= DUTY_RST;
      fault_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      duty_q  <= duty_d;
      fault_q <= fault_d;
      upd_q   <= upd_d;
    end
  end

`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
  // The ceiling survives en_i dropping; only reset brings it back to 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceil_q <= 2'b00;
    end else begin
      ceil_q <= ceil_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    win_d   = win_q;
    ones_d  = ones_q;
    duty_d  = duty_q;
    fault_d = fault_q;
    upd_d   = 1'b0;
`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
    ceil_d  = ceil_q;
`endif

    if (!en_i) begin
      // Disabled: restart from SETTLE. This also drops a pending decision.
      state_d = S_SETTLE;
      tmr_d   = '0;
      win_d   = '0;
      ones_d  = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (tmr_q == TMR_W'(SETTLE - 1)) begin
            state_d = S_MEASURE;
            tmr_d   = '0;
            win_d   = '0;
            ones_d  = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        S_MEASURE: begin
          if (cmp_s_q && (ones_q != CNT_W'(WINDOW))) begin
            ones_d = ones_q + 1'b1;
          end
          if (win_q == CNT_W'(WINDOW - 1)) begin
            state_d = S_DECIDE;
            win_d   = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end

        S_DECIDE: begin
          state_d = S_BLANK;
          tmr_d   = '0;
          upd_d   = 1'b1;
          fault_d = (ones_q == CNT_W'(WINDOW));
`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
          ceil_d  = sat_inc2(ceil_q);
          duty_d  = (step_duty(duty_q, ones_q) > ceil_d) ? ceil_d
                                                         : step_duty(duty_q, ones_q);
`else
          duty_d  = step_duty(duty_q, ones_q);
`endif
        end

        S_BLANK: begin
          if (tmr_q == TMR_W'(BLANK - 1)) begin
            state_d = S_MEASURE;
            tmr_d   = '0;
            win_d   = '0;
            ones_d  = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        default: begin
          state_d = S_SETTLE;
          tmr_d   = '0;
          win_d   = '0;
          ones_d  = '0;
        end
      endcase
    end
  end

`ifndef FLYBACK_FEEDBACK_SOFTSTART_EN
  // Keeps the helper referenced in builds without the ceiling.
  logic [1:0] unused_inc;
  assign unused_inc = sat_inc2(2'b00);
`endif

  // ---- outputs ----
  assign dutycyc_o = duty_q;
  assign upd_o     = upd_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_flyback_feedback.sv
// ----------------------------------------------------------------------------
// tb_flyback_feedback
//
// Directed bench for flyback_feedback. The reference model does not track
// an FSM. It derives the decision edges from the enable/reset history:
//   decision edge = run start + SETTLE + WINDOW + k * (WINDOW + 1 + BLANK)
// It counts the comparator samples that fall inside each window straight
// from a record of the pin value at every edge. The outputs are compared
// against the model at every negedge. Hand-computed literals pin the key
// edges.
// ----------------------------------------------------------------------------
module tb_flyback_feedback;

  localparam int WINDOW = 21;
  localparam int HI_THR = 14;
  localparam int LO_THR = 6;
  localparam int SETTLE = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = WINDOW + 1 + BLANK;
  localparam int HN     = 4096;

`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
  localparam logic [1:0] RST_DUTY = 2'b00;
`else
  localparam logic [1:0] RST_DUTY = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       rst_async_n = 1'b0;
  logic       cmp_async_i = 1'b0;
  logic       en_i = 1'b1;
  logic [1:0] dutycyc_o;
  logic       upd_o;
  logic       fault_o;

  flyback_feedback #(
    .WINDOW(WINDOW), .HI_THR(HI_THR), .LO_THR(LO_THR),
    .SETTLE(SETTLE), .BLANK(BLANK)
  ) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .cmp_async_i (cmp_async_i),
    .en_i        (en_i),
    .dutycyc_o   (dutycyc_o),
    .upd_o       (upd_o),
    .fault_o     (fault_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         hist [0:HN-1];
  int         edge_n  = 0;
  int         rel_cnt = 0;
  bit         run     = 1'b0;
  int         run_r   = 0;
  logic [1:0] m_duty  = RST_DUTY;
  logic       m_upd   = 1'b0;
  logic       m_fault = 1'b0;
  logic [1:0] m_ceil  = 2'b00;

  always @(posedge clk or negedge rst_async_n) begin
    int d;
    int ones;
    int nd;
    if (!rst_async_n) begin
      m_duty  = RST_DUTY;
      m_upd   = 1'b0;
      m_fault = 1'b0;
      m_ceil  = 2'b00;
      run     = 1'b0;
      rel_cnt = 0;
    end else begin
      edge_n = edge_n + 1;
      hist[edge_n % HN] = cmp_async_i;
      m_upd = 1'b0;
      if (rel_cnt < 2) begin
        rel_cnt = rel_cnt + 1;
      end else if (!en_i) begin
        run = 1'b0;
      end else begin
        if (!run) begin
          run   = 1'b1;
          run_r = edge_n;
        end
        d = edge_n - run_r - SETTLE - WINDOW;
        if (d >= 0 && (d % PERIOD) == 0) begin
          ones = 0;
          for (int e = edge_n - WINDOW; e < edge_n; e++)
            ones += int'(hist[(e - 2) % HN]);
          nd = int'(m_duty);
          if (ones >= WINDOW)       nd = 0;
          else if (ones >= HI_THR)  nd = (nd > 0) ? nd - 1 : 0;
          else if (ones <= LO_THR)  nd = (nd < 3) ? nd + 1 : 3;
`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
          m_ceil = (m_ceil == 2'b11) ? 2'b11 : m_ceil + 2'd1;
          if (nd > int'(m_ceil)) nd = int'(m_ceil);
`endif
          m_duty  = 2'(nd);
          m_fault = (ones >= WINDOW);
          m_upd   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Number of high samples placed at the start of window k (0-based).
  function automatic int highs(input int k);
    case (k)
      3: return 15;
      4: return 10;
      6: return 21;
      7: return 5;
      default: return 0;
    endcase
  endfunction

  // Comparator value to be sampled at post-release edge n. Window k of an
  // undisturbed run samples pin edges 5+24k .. 25+24k.
  function automatic logic pat(input int n);
    int k;
    int off;
    if (n < 5 || n > 200) return 1'b0;
    k   = (n - 5) / PERIOD;
    off = (n - 5) % PERIOD;
    return (k < 8 && off < WINDOW && off < highs(k)) ? 1'b1 : 1'b0;
  endfunction

  // Hand-computed duty after decision k (0-based, decision edge 28+24k).
  function automatic int lit_duty(input int k);
    case (k)
`ifdef FLYBACK_FEEDBACK_SOFTSTART_EN
      0: return 1;
      1: return 2;
`else
      0: return 2;
      1: return 3;
`endif
      2: return 3;
      3: return 2;
      4: return 2;
      5: return 3;
      6: return 0;
      7: return 1;
      default: return -1;
    endcase
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input int n);
    chk($sformatf("model n=%0d {duty,upd,fault}", n),
        int'({dutycyc_o, upd_o, fault_o}), int'({m_duty, m_upd, m_fault}));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset duty", int'(dutycyc_o), int'(RST_DUTY));
    chk("reset upd", int'(upd_o), 0);
    chk("reset fault", int'(fault_o), 0);
    chk_model(0);

    // Phase 1: startup, duty stepping, fault, and an enable dropout.
    rst_async_n = 1'b1;
    for (int n = 1; n <= 240; n++) begin
      en_i        = !(n >= 205 && n <= 207);
      cmp_async_i = pat(n);
      @(posedge clk);
      @(negedge clk);
      chk_model(n);
      if (n == 27) chk("upd before first decision", int'(upd_o), 0);
      if (n >= 28 && n <= 196 && ((n - 28) % PERIOD) == 0) begin
        k = (n - 28) / PERIOD;
        chk($sformatf("decision %0d upd", k), int'(upd_o), 1);
        chk($sformatf("decision %0d duty", k), int'(dutycyc_o), lit_duty(k));
        chk($sformatf("decision %0d fault", k), int'(fault_o), (k == 6) ? 1 : 0);
      end
      if (n == 29) chk("upd one cycle wide", int'(upd_o), 0);
      if (n == 207) chk("duty frozen while disabled", int'(dutycyc_o), 1);
      if (n == 220) chk("suppressed decision upd", int'(upd_o), 0);
      if (n == 232) chk("upd before re-enable decision", int'(upd_o), 0);
      if (n == 233) begin
        chk("re-enable decision upd", int'(upd_o), 1);
        chk("re-enable decision duty", int'(dutycyc_o), 2);
      end
    end

    // Phase 2: reset mid-window acts without a clock edge.
    #2;
    rst_async_n = 1'b0;
    #1;
    chk("async reset duty", int'(dutycyc_o), int'(RST_DUTY));
    chk("async reset upd", int'(upd_o), 0);
    chk("async reset fault", int'(fault_o), 0);
    chk_model(-1);
    repeat (2) @(negedge clk);
    chk_model(-2);

    rst_async_n = 1'b1;
    cmp_async_i = 1'b0;
    en_i        = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk_model(1000 + n);
      if (n == 27) chk("post-reset upd early", int'(upd_o), 0);
      if (n == 28) begin
        chk("post-reset first upd", int'(upd_o), 1);
        chk("post-reset first duty", int'(dutycyc_o), lit_duty(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
